// File: rtl/aula0511_qsys_stream_mem_loader.sv
// Byte-stream to Avalon-MM word loader for single-port on-chip RAM.
// Packs bytes little-endian and writes sequential words from a base address.
module aula0511_qsys_stream_mem_loader #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 10240
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [14:0]       word_limit,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [14:0]       words_written
);

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [14:0]       lim;
    logic [14:0]       cnt;
    logic [1:0]        lane;
    logic [31:0]       data_reg;
    logic [3:0]        be_reg;
    logic              last_seen;

    logic              xfer;
    logic [3:0]        be_nxt;
    logic [14:0]       cnt_inc;
    logic              ptr_top;

    assign xfer    = in_valid & in_ready;
    assign be_nxt  = be_reg | (4'b0001 << lane);
    assign cnt_inc = cnt + 15'd1;
    assign ptr_top = (ptr == ADDR_W'(DEPTH - 1));

    // Address and data come straight from the working registers;
    // the byte enable and strobes qualify them in WRITE only.
    assign m_address   = ptr;
    assign m_writedata = data_reg;
    assign m_clken     = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= '0;
            lim           <= '0;
            cnt           <= '0;
            lane          <= '0;
            data_reg      <= '0;
            be_reg        <= '0;
            last_seen     <= 1'b0;
            in_ready      <= 1'b0;
            m_byteenable  <= '0;
            m_chipselect  <= 1'b0;
            m_write       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            words_written <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ptr           <= base_addr;
                        lim           <= word_limit;
                        cnt           <= '0;
                        lane          <= '0;
                        data_reg      <= '0;
                        be_reg        <= '0;
                        last_seen     <= 1'b0;
                        overflow      <= 1'b0;
                        words_written <= '0;
                        if (word_limit == 15'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= PACK;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                PACK: begin
                    if (xfer) begin
                        data_reg[8*lane +: 8] <= in_data;
                        be_reg                <= be_nxt;
                        lane                  <= lane + 2'd1;
                        if (lane == 2'd3 || in_last) begin
                            state        <= WRITE;
                            last_seen    <= in_last;
                            in_ready     <= 1'b0;
                            m_chipselect <= 1'b1;
                            m_write      <= 1'b1;
                            m_byteenable <= be_nxt;
                        end
                    end
                end
                WRITE: begin
                    m_chipselect  <= 1'b0;
                    m_write       <= 1'b0;
                    m_byteenable  <= '0;
                    ptr           <= ptr_top ? '0 : ptr + 1'b1;
                    cnt           <= cnt_inc;
                    words_written <= cnt_inc;
                    lane          <= '0;
                    data_reg      <= '0;
                    be_reg        <= '0;
                    if (last_seen) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (cnt_inc == lim) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        overflow <= 1'b1;
                    end else begin
                        state    <= PACK;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
